mul_share_arb: RTL
==================

Name: mul_share_arb

Overview:
- Round-robin scheduler that shares one pipelined signed 16x16 multiplier among N_REQ requesters.
- Each requester presents an operand pair with a valid/ready handshake.
- The block grants at most one requester per cycle, pushes its operands into the multiplier pipeline with an id tag, and returns a 32-bit product with that tag.
- Sits between several processing units and the single multiplier datapath in the lab top level.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- DW, 16, operand width (signed two's complement)
- LAT, 2, multiplier pipeline depth in cycles (1..4)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  N_REQ  requester i has an operand pair pending
- req_a  in  N_REQ*DW  operand A, slice i = [i*DW +: DW]
- req_b  in  N_REQ*DW  operand B, same slicing
- req_ready  out  N_REQ  one-hot (or zero) grant; transfer on valid&ready
- rsp_valid  out  1  result valid
- rsp_id  out  $clog2(N_REQ)  requester index of the result
- rsp_data  out  2*DW  signed product a*b
- rsp_ready  in  1  consumer accepts result
- busy  out  1  any stage of the pipeline holds a valid entry

Behaviour:
- Reset (rst=1 at clk edge):
  - rr_ptr=0; all pipeline valid bits=0.
  - rsp_valid=0, rsp_id=0, rsp_data=0, busy=0.
  - req_ready=0 while rst is high.
  - Reset mid-operation discards all in-flight products; no response is emitted for them.
- stall = rsp_valid & ~rsp_ready.
  - While stalled, no pipeline stage advances, req_ready=0, and rsp_* hold stable.
- Arbitration (combinational, no stall):
  - Grant the first i with req_valid[i]=1, searching from rr_ptr upward and wrapping N_REQ-1 -> 0.
  - req_ready is one-hot on that i; it is zero if no request or stall.
- Pointer update: on a transfer to index g, rr_ptr <= (g+1) mod N_REQ. Otherwise rr_ptr holds.
- Fairness: a continuously asserting requester waits at most N_REQ-1 grants.
- Pipeline:
  - Stage 0 registers a, b, id and valid on transfer. Stage 0 valid=0 if no transfer.
  - Stages 1..LAT-1 shift when not stalled.
  - The multiply is registered in the final stage as signed(a)*signed(b), full 2*DW bits, no truncation or saturation.
  - Outputs are driven from the final stage.
- Latency: transfer at edge k -> rsp_valid at edge k+LAT, absent stalls.
- Throughput: 1 result per cycle.
- Bubbles (cycles with no transfer) propagate as rsp_valid=0.
- Output ordering equals grant order.
- Requesters may change a/b only after their transfer. Operands are not re-sampled while waiting.
- rsp_ready ignored when rsp_valid=0 (not a stall).
- Corner case: (-2^(DW-1))*(-2^(DW-1)) = 2^(2DW-2), positive, representable.

Decomposition:
- Package mul_share_pkg: ID_W = $clog2(N_REQ) helper, typedef pipe_tag_t {valid, id}, DW default constant.
- One sub-module: mul_pipe (LAT-stage signed multiplier with enable and tag shift). The arbiter and pointer logic stay in mul_share_arb.

Test Plan:
- Reset then single req: req_valid[0]=1, a=2615, b=2615 -> req_ready[0] in same cycle; LAT cycles later rsp_valid=1, rsp_id=0, rsp_data=6838225.
- Signed mix: req 2 with a=-17412, b=2615 -> rsp_id=2, rsp_data=-45532380 (32'hFD493B24). Then a=b=-17412 -> 303177744.
- All four requesters valid for 8 cycles with rr_ptr=0:
  - Grants go 0,1,2,3,0,1,2,3.
  - Responses return in the same id order, one per cycle after LAT.
- Backpressure: hold rsp_ready=0 for 3 cycles while rsp_valid=1:
  - rsp_data and rsp_id are stable.
  - req_ready=0 throughout.
  - No result is lost or duplicated after release.
- Extremes: a=b=-32768 -> 1073741824. Also a=-32768, b=32767 -> -1073709056.
- Reset mid-flight: assert rst with 2 entries in the pipe -> next cycle rsp_valid=0 and busy=0. No stale response afterwards; first post-reset grant goes to the lowest valid index.

Source files
------------

// File: rtl/mul_share_pkg.sv
// Shared types and helpers for the multiplier-sharing arbiter.
package mul_share_pkg;

  localparam int unsigned DW_DEFAULT = 16;
  // Wide enough for an index into up to 8 requesters.
  localparam int unsigned MAX_ID_W   = 3;

  typedef struct packed {
    logic                valid;
    logic [MAX_ID_W-1:0] id;
  } pipe_tag_t;

  function automatic int id_width(int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mul_share_arb_if.sv
// Requester and response bundle between processing units and the shared multiplier.
interface mul_share_arb_if
  import mul_share_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int DW    = 16
) ();

  localparam int ID_W = id_width(N_REQ);

  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ*DW-1:0] req_a;
  logic [N_REQ*DW-1:0] req_b;
  logic [N_REQ-1:0]    req_ready;
  logic                rsp_valid;
  logic [ID_W-1:0]     rsp_id;
  logic [2*DW-1:0]     rsp_data;
  logic                rsp_ready;
  logic                busy;

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, busy
  );

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, busy
  );

endinterface

// File: rtl/mul_pipe.sv
// LAT-stage signed multiplier; operands and id tag shift together, product registered last.
module mul_pipe
  import mul_share_pkg::*;
#(
  parameter int DW  = DW_DEFAULT,
  parameter int LAT = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en_i,
  input  pipe_tag_t              tag_i,
  input  logic signed [DW-1:0]   a_i,
  input  logic signed [DW-1:0]   b_i,
  output pipe_tag_t              tag_o,
  output logic signed [2*DW-1:0] prod_o,
  output logic                   busy_o
);

  pipe_tag_t              tag_q [LAT];
  pipe_tag_t              fin_tag;
  logic signed [DW-1:0]   mul_a, mul_b;
  logic signed [2*DW-1:0] ext_a, ext_b, prod_q;

  if (LAT == 1) begin : g_direct
    assign mul_a   = a_i;
    assign mul_b   = b_i;
    assign fin_tag = tag_i;
  end else begin : g_opd
    logic signed [DW-1:0] a_q [LAT-1];
    logic signed [DW-1:0] b_q [LAT-1];

    always_ff @(posedge clk) begin
      if (en_i) begin
        a_q[0] <= a_i;
        b_q[0] <= b_i;
        for (int j = 1; j < LAT - 1; j++) begin
          a_q[j] <= a_q[j-1];
          b_q[j] <= b_q[j-1];
        end
      end
    end

    assign mul_a   = a_q[LAT-2];
    assign mul_b   = b_q[LAT-2];
    assign fin_tag = tag_q[LAT-2];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < LAT; j++) tag_q[j] <= '0;
    end else if (en_i) begin
      tag_q[0] <= tag_i;
      for (int j = 1; j < LAT; j++) tag_q[j] <= tag_q[j-1];
    end
  end

  // Sign-extend to the full product width so the low 2*DW bits are exact.
  assign ext_a = {{DW{mul_a[DW-1]}}, mul_a};
  assign ext_b = {{DW{mul_b[DW-1]}}, mul_b};

  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q <= '0;
    end else if (en_i && fin_tag.valid) begin
      prod_q <= ext_a * ext_b;
    end
  end

  always_comb begin
    busy_o = 1'b0;
    for (int j = 0; j < LAT; j++) busy_o = busy_o | tag_q[j].valid;
  end

  assign tag_o  = tag_q[LAT-1];
  assign prod_o = prod_q;

endmodule

// File: rtl/mul_share_arb.sv
// Round-robin arbiter that feeds one pipelined signed multiplier from N_REQ requesters.
module mul_share_arb
  import mul_share_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int DW    = DW_DEFAULT,
  parameter int LAT   = 2
) (
  input  logic            clk,
  input  logic            rst,
  mul_share_arb_if.slave  bus
);

  localparam int ID_W = id_width(N_REQ);

  logic [ID_W-1:0]        rr_q, rr_d, gnt_idx, cidx;
  logic [ID_W:0]          csum;
  logic                   gnt_found, stall, xfer;
  logic [N_REQ-1:0]       ready;
  pipe_tag_t              in_tag, out_tag;
  logic signed [DW-1:0]   in_a, in_b;
  logic signed [2*DW-1:0] prod;
  logic                   pipe_busy;
  logic                   unused_tag_id;

  assign stall = out_tag.valid & ~bus.rsp_ready;

  // First valid requester at or after rr_q, wrapping at N_REQ.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    csum      = '0;
    cidx      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      csum = {1'b0, rr_q} + (ID_W+1)'(k);
      cidx = (csum >= (ID_W+1)'(N_REQ)) ? ID_W'(csum - (ID_W+1)'(N_REQ)) : ID_W'(csum);
      if (!gnt_found && bus.req_valid[cidx]) begin
        gnt_found = 1'b1;
        gnt_idx   = cidx;
      end
    end
  end

  always_comb begin
    ready = '0;
    if (!rst && !stall && gnt_found) ready[gnt_idx] = 1'b1;
  end

  assign xfer          = |ready;
  assign bus.req_ready = ready;

  assign rr_d = !xfer                        ? rr_q :
                (gnt_idx == ID_W'(N_REQ-1))  ? '0   : gnt_idx + ID_W'(1);

  always_ff @(posedge clk) begin
    if (rst) rr_q <= '0;
    else     rr_q <= rr_d;
  end

  always_comb begin
    in_tag       = '0;
    in_tag.valid = xfer;
    if (xfer) in_tag.id = MAX_ID_W'(gnt_idx);
  end

  assign in_a = bus.req_a[int'(gnt_idx)*DW +: DW];
  assign in_b = bus.req_b[int'(gnt_idx)*DW +: DW];

  mul_pipe #(
    .DW  (DW),
    .LAT (LAT)
  ) u_mul_pipe (
    .clk    (clk),
    .rst    (rst),
    .en_i   (~stall),
    .tag_i  (in_tag),
    .a_i    (in_a),
    .b_i    (in_b),
    .tag_o  (out_tag),
    .prod_o (prod),
    .busy_o (pipe_busy)
  );

  assign bus.rsp_valid = out_tag.valid;
  assign bus.rsp_id    = out_tag.id[ID_W-1:0];
  assign bus.rsp_data  = prod;
  assign bus.busy      = pipe_busy;

  // Tag ids are zero-padded above ID_W.
  assign unused_tag_id = ^out_tag.id;

endmodule
